// File: rtl/craft_pkg.sv
// Shared CRAFT-64 constants, tables, LFSR helpers and controller state type.
// Nibble i of any 64-bit word lives at bits [63-4i -: 4].
package craft_pkg;

   localparam int CRAFT_ROUNDS = 32;

   // Tables packed with entry 0 in the top nibble
   localparam logic [63:0] SBOX_TBL = 64'hCAD3EBF789150246;
   localparam logic [63:0] Q_TBL    = 64'hCAF5E892B374601D;
   localparam logic [63:0] PN_TBL   = 64'hFCDEA98B65471230;

   localparam logic [3:0] RC4_SEED = 4'h1;
   localparam logic [2:0] RC3_SEED = 3'h1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } craft_state_t;

   function automatic logic [3:0] nib(input logic [63:0] v, input logic [3:0] i);
      logic [63:0] s;
      s = v << {i, 2'b00};
      return s[63:60];
   endfunction

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return nib(SBOX_TBL, x);
   endfunction

   // Q(T): output nibble i takes tweak nibble Q[i]
   function automatic logic [63:0] q_perm(input logic [63:0] t);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r = {r[59:0], nib(t, nib(Q_TBL, 4'(i)))};
      end
      return r;
   endfunction

   function automatic logic [3:0] lfsr4_step(input logic [3:0] a);
      return {a[1] ^ a[0], a[3:1]};
   endfunction

   function automatic logic [2:0] lfsr3_step(input logic [2:0] b);
      return {b[1] ^ b[0], b[2:1]};
   endfunction

endpackage

// File: rtl/craft_digit_round.sv
// One DW-bit digit of a CRAFT round: MixColumn, AddConstant, AddTweakey, S-box.
// Operands arrive already gathered per nibble lane by the caller.
module craft_digit_round
   import craft_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic [DW-1:0] own,
   input  logic [DW-1:0] mix,
   input  logic [DW-1:0] rc,
   input  logic [DW-1:0] tk,
   input  logic          last,
   output logic [DW-1:0] dout
);

   for (genvar gi = 0; gi < DW / 4; gi++) begin : g_lane
      logic [3:0] t;
      assign t = own[4*gi +: 4] ^ mix[4*gi +: 4] ^ rc[4*gi +: 4] ^ tk[4*gi +: 4];
      // The final round stops after AddTweakey
      assign dout[4*gi +: 4] = last ? t : sbox(t);
   end

endmodule

// File: rtl/craft_serial_core.sv
// Iterative CRAFT-64 encryption core, DW bits per cycle, 64/DW cycles per round.
// Define CRAFT_TK_OBS_EN to expose the current round tweakey on tk_obs.
module craft_serial_core
   import craft_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  plaintext,
   input  logic [63:0]  tweak,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  ciphertext,
   output logic         busy,
`ifdef CRAFT_TK_OBS_EN
   output logic [63:0]  tk_obs,
`endif
   output logic [4:0]   round_idx
);

   localparam int D  = 64 / DW;
   localparam int L  = DW / 4;
   localparam int CW = (D > 1) ? $clog2(D) : 1;

   if (DW != 4 && DW != 8 && DW != 16 && DW != 64) begin : g_bad_dw
      $error("craft_serial_core: DW must be 4, 8, 16 or 64");
   end

   craft_state_t   state_reg;
   logic [63:0]    blk_reg;
   logic [63:0]    acc_reg;
   logic [63:0]    ct_reg;
   logic [63:0]    tk_reg [4];
   logic [3:0]     rc4_reg;
   logic [2:0]     rc3_reg;
   logic [CW-1:0]  digit_reg;
   logic [4:0]     round_reg;
   logic           in_ready_reg;
   logic           out_valid_reg;
   logic           busy_reg;

   logic [DW-1:0]  own_digit, mix_digit, rc_digit, tk_digit, round_digit;
   logic [63:0]    acc_next;
   logic [63:0]    tk0_init;
   logic [5:0]     acc_base;
   logic           start, wrap, last_round;

   assign start      = in_valid && in_ready_reg;
   assign wrap       = (digit_reg == CW'(D - 1));
   assign last_round = (round_reg == 5'(CRAFT_ROUNDS - 1));
   assign tk0_init   = key[127:64] ^ tweak;

   // blk_reg holds the round input untouched for the whole round; each output
   // nibble gathers its pre-permutation source, so no in-place hazards arise.
   for (genvar gi = 0; gi < L; gi++) begin : g_gather
      logic [3:0] pos, src;
      assign pos = 4'(int'(digit_reg) * L + gi);
      assign src = last_round ? pos : nib(PN_TBL, pos);
      assign own_digit[DW-4-4*gi +: 4] = nib(blk_reg, src);
      assign mix_digit[DW-4-4*gi +: 4] =
         (src[3:2] == 2'd0) ? (nib(blk_reg, src + 4'd8) ^ nib(blk_reg, src + 4'd12)) :
         (src[3:2] == 2'd1) ?  nib(blk_reg, src + 4'd8) : 4'h0;
      assign rc_digit[DW-4-4*gi +: 4] =
         (src == 4'd4) ? rc4_reg : (src == 4'd5) ? {1'b0, rc3_reg} : 4'h0;
      assign tk_digit[DW-4-4*gi +: 4] = nib(tk_reg[0], src);
   end

   craft_digit_round #(.DW(DW)) u_digit_round (
      .own  (own_digit),
      .mix  (mix_digit),
      .rc   (rc_digit),
      .tk   (tk_digit),
      .last (last_round),
      .dout (round_digit)
   );

   assign acc_base = 6'(64 - DW * (int'(digit_reg) + 1));

   always_comb begin
      acc_next = acc_reg;
      acc_next[acc_base +: DW] = round_digit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         blk_reg       <= '0;
         acc_reg       <= '0;
         ct_reg        <= '0;
         for (int i = 0; i < 4; i++) tk_reg[i] <= '0;
         rc4_reg       <= '0;
         rc3_reg       <= '0;
         digit_reg     <= '0;
         round_reg     <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  blk_reg      <= plaintext;
                  tk_reg[0]    <= tk0_init;
                  tk_reg[1]    <= key[63:0] ^ tweak;
                  tk_reg[2]    <= key[127:64] ^ q_perm(tweak);
                  tk_reg[3]    <= key[63:0] ^ q_perm(tweak);
                  rc4_reg      <= RC4_SEED;
                  rc3_reg      <= RC3_SEED;
                  digit_reg    <= '0;
                  round_reg    <= '0;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_reg <= acc_next;
               if (wrap) begin
                  digit_reg <= '0;
                  blk_reg   <= acc_next;
                  // Tweakey ring rotates so tk_reg[0] is always TK[round mod 4]
                  tk_reg[0] <= tk_reg[1];
                  tk_reg[1] <= tk_reg[2];
                  tk_reg[2] <= tk_reg[3];
                  tk_reg[3] <= tk_reg[0];
                  rc4_reg   <= lfsr4_step(rc4_reg);
                  rc3_reg   <= lfsr3_step(rc3_reg);
                  if (last_round) begin
                     ct_reg        <= acc_next;
                     out_valid_reg <= 1'b1;
                     busy_reg      <= 1'b0;
                     state_reg     <= ST_DONE;
                  end else begin
                     round_reg <= round_reg + 5'd1;
                  end
               end else begin
                  digit_reg <= digit_reg + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef CRAFT_TK_OBS_EN
   logic [63:0] tk_obs_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tk_obs_reg <= '0;
      end else if (start) begin
         tk_obs_reg <= tk0_init;
      end else if (state_reg == ST_RUN && wrap) begin
         tk_obs_reg <= last_round ? 64'h0 : tk_reg[1];
      end
   end

   assign tk_obs = tk_obs_reg;
`endif

   assign in_ready   = in_ready_reg;
   assign out_valid  = out_valid_reg;
   assign ciphertext = ct_reg;
   assign busy       = busy_reg;
   assign round_idx  = round_reg;

endmodule

// File: tb/tb_craft_serial_core.sv
// Directed bench for craft_serial_core: four instances (DW=4/8/16/64) share stimulus;
// ciphertexts are checked against a full-state CRAFT-64 reference function.
module tb_craft_serial_core;

   localparam logic [127:0] K1V = 128'h27A6781A43F364BC916708D5FBB5AEFE;
   localparam logic [63:0]  T1V = 64'h54CD94FFD0670A58;
   localparam logic [63:0]  P1V = 64'h5734F006D8D88A3E;
   localparam logic [127:0] K2V = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [63:0]  T2V = 64'hFEDCBA9876543210;
   localparam logic [63:0]  P2V = 64'h0123456789ABCDEF;

   localparam int SBOX_T [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
   localparam int Q_T    [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
   localparam int PN_T   [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};

   logic         clk = 1'b0;
   logic         rst_n, in_valid, out_ready;
   logic         ready_hi = 1'b1;
   logic [63:0]  plaintext, tweak;
   logic [127:0] key;

   logic        in_ready_4, out_valid_4, busy_4;
   logic        in_ready_8, out_valid_8, busy_8;
   logic        in_ready_16, out_valid_16, busy_16;
   logic        in_ready_64, out_valid_64, busy_64;
   logic [63:0] ct_4, ct_8, ct_16, ct_64;
   logic [4:0]  round_4, round_8, round_16, round_64;
`ifdef CRAFT_TK_OBS_EN
   logic [63:0] tk_obs_4, tk_obs_8, tk_obs_16, tk_obs_64;
`endif

   int total = 0;
   int bad   = 0;
   int cyc;

   always #5 clk = ~clk;

   craft_serial_core #(.DW(4)) u_dw4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
      .plaintext(plaintext), .tweak(tweak), .key(key), .out_valid(out_valid_4),
      .out_ready(out_ready), .ciphertext(ct_4), .busy(busy_4),
`ifdef CRAFT_TK_OBS_EN
      .tk_obs(tk_obs_4),
`endif
      .round_idx(round_4));

   craft_serial_core #(.DW(8)) u_dw8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_8),
      .plaintext(plaintext), .tweak(tweak), .key(key), .out_valid(out_valid_8),
      .out_ready(ready_hi), .ciphertext(ct_8), .busy(busy_8),
`ifdef CRAFT_TK_OBS_EN
      .tk_obs(tk_obs_8),
`endif
      .round_idx(round_8));

   craft_serial_core #(.DW(16)) u_dw16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_16),
      .plaintext(plaintext), .tweak(tweak), .key(key), .out_valid(out_valid_16),
      .out_ready(ready_hi), .ciphertext(ct_16), .busy(busy_16),
`ifdef CRAFT_TK_OBS_EN
      .tk_obs(tk_obs_16),
`endif
      .round_idx(round_16));

   craft_serial_core #(.DW(64)) u_dw64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_64),
      .plaintext(plaintext), .tweak(tweak), .key(key), .out_valid(out_valid_64),
      .out_ready(ready_hi), .ciphertext(ct_64), .busy(busy_64),
`ifdef CRAFT_TK_OBS_EN
      .tk_obs(tk_obs_64),
`endif
      .round_idx(round_64));

   function automatic logic [3:0] nibble(input logic [63:0] v, input int i);
      return 4'(v >> (60 - 4 * i));
   endfunction

   function automatic logic [63:0] craft_model(input logic [63:0] p, input logic [63:0] t,
                                               input logic [127:0] k);
      logic [3:0]  s [16];
      logic [3:0]  m [16];
      logic [3:0]  tk [4][16];
      logic [3:0]  a;
      logic [2:0]  b;
      logic [63:0] res;
      for (int i = 0; i < 16; i++) begin
         s[i]     = nibble(p, i);
         tk[0][i] = nibble(k[127:64], i) ^ nibble(t, i);
         tk[1][i] = nibble(k[63:0], i)   ^ nibble(t, i);
         tk[2][i] = nibble(k[127:64], i) ^ nibble(t, Q_T[i]);
         tk[3][i] = nibble(k[63:0], i)   ^ nibble(t, Q_T[i]);
      end
      a = 4'h1;
      b = 3'h1;
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 4; c++) begin
            m[c]      = s[c] ^ s[c+8] ^ s[c+12];
            m[c + 4]  = s[c+4] ^ s[c+12];
            m[c + 8]  = s[c+8];
            m[c + 12] = s[c+12];
         end
         m[4] = m[4] ^ a;
         m[5] = m[5] ^ {1'b0, b};
         for (int i = 0; i < 16; i++) m[i] = m[i] ^ tk[r % 4][i];
         a = {a[1] ^ a[0], a[3:1]};
         b = {b[1] ^ b[0], b[2:1]};
         for (int i = 0; i < 16; i++) s[i] = (r == 31) ? m[i] : 4'(SBOX_T[m[PN_T[i]]]);
      end
      res = '0;
      for (int i = 0; i < 16; i++) res = {res[59:0], s[i]};
      return res;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_block(input logic [63:0] p, input logic [63:0] t, input logic [127:0] k);
      @(negedge clk);
      plaintext = p;
      tweak     = t;
      key       = k;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc      = 1;
      $display("start P=%h T=%h", p, t);
   endtask

   initial begin
      logic [63:0] exp1, exp2, ct_seen, ct_first;
      int c4, c8, c16, c64, nout;
      exp1 = craft_model(P1V, T1V, K1V);
      exp2 = craft_model(P2V, T2V, K2V);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      plaintext = '0; tweak = '0; key = '0; cyc = 0;

      // Reset state, with and after reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready_4), 64'd1);
      check("rst_out_valid", 64'(out_valid_4), 64'd0);
      check("rst_ciphertext", ct_4, 64'd0);
      check("rst_busy", 64'(busy_4), 64'd0);
      check("rst_round", 64'(round_4), 64'd0);
`ifdef CRAFT_TK_OBS_EN
      check("rst_tk_obs", tk_obs_4, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) tick();
      check("idle_in_ready", 64'(in_ready_4), 64'd1);
      check("idle_out_valid", 64'(out_valid_4), 64'd0);
      check("idle_ciphertext", ct_4, 64'd0);
      check("idle_busy", 64'(busy_64), 64'd0);

      // Known vector on all widths; DW=4 is held with out_ready low
      start_block(P1V, T1V, K1V);
      check("cap_busy", 64'(busy_4), 64'd1);
      check("cap_in_ready", 64'(in_ready_4), 64'd0);
      check("cap_round", 64'(round_4), 64'd0);
      check("cap_busy16", 64'(busy_16), 64'd1);
`ifdef CRAFT_TK_OBS_EN
      check("tk_obs_r0", tk_obs_4, 64'h736BECE593946EE4);
      check("tk_obs_r0_dw8", tk_obs_8, 64'h736BECE593946EE4);
`endif
      c4 = 0; c8 = 0; c16 = 0; c64 = 0;
      while (c4 == 0 && cyc < 700) begin
         if (out_valid_8  && c8  == 0) begin c8  = cyc; check("ct_dw8",  ct_8,  exp1); end
         if (out_valid_16 && c16 == 0) begin c16 = cyc; check("ct_dw16", ct_16, exp1); end
         if (out_valid_64 && c64 == 0) begin c64 = cyc; check("ct_dw64", ct_64, exp1); end
         if (out_valid_4) c4 = cyc;
         if (cyc == 16) check("round_end_r0", 64'(round_4), 64'd0);
         if (cyc == 17) begin
            check("round_r1", 64'(round_4), 64'd1);
`ifdef CRAFT_TK_OBS_EN
            check("tk_obs_r1", tk_obs_4, 64'hC5AA9C2A2BD2A4A6);
`endif
         end
         if (c4 == 0) tick();
      end
      $display("latency dw4=%0d dw8=%0d dw16=%0d dw64=%0d", c4, c8, c16, c64);
      check("lat_dw4", 64'(c4), 64'd513);
      check("lat_dw8", 64'(c8), 64'd257);
      check("lat_dw16", 64'(c16), 64'd129);
      check("lat_dw64", 64'(c64), 64'd33);
      check("ct_dw4", ct_4, exp1);

      // Backpressure: 20 cycles with out_ready low
      ct_seen = ct_4;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_ct_stable", ct_4, ct_seen);
         check("bp_in_ready", 64'(in_ready_4), 64'd0);
      end
      check("bp_out_valid", 64'(out_valid_4), 64'd1);
      @(negedge clk);
      out_ready = 1'b1;
      tick();
      check("acc_out_valid", 64'(out_valid_4), 64'd0);
      check("acc_in_ready", 64'(in_ready_4), 64'd1);
      $display("accepted ct=%h", ct_seen);

      // Start request and input changes during RUN are ignored
      start_block(P1V, T1V, K1V);
      nout = 0;
      ct_first = '0;
      while (cyc < 560) begin
         if (out_valid_4) begin
            if (nout == 0) ct_first = ct_4;
            nout++;
         end
         if (cyc == 42) check("ign_busy", 64'(busy_4), 64'd1);
         if (cyc >= 40 && cyc < 45) begin
            in_valid = 1'b1; plaintext = P2V; tweak = T2V; key = K2V;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      $display("ignored-start outputs=%0d ct=%h", nout, ct_first);
      check("ign_count", 64'(nout), 64'd1);
      check("ign_ct", ct_first, exp1);

      // Reset in round 10
      start_block(P2V, T2V, K2V);
      while (round_4 != 5'd10 && cyc < 1000) tick();
      check("mid_round10", 64'(round_4), 64'd10);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_busy", 64'(busy_4), 64'd0);
      check("mid_in_ready", 64'(in_ready_4), 64'd1);
      check("mid_out_valid", 64'(out_valid_4), 64'd0);
      check("mid_round", 64'(round_4), 64'd0);
      check("mid_ciphertext", ct_4, 64'd0);
`ifdef CRAFT_TK_OBS_EN
      check("mid_tk_obs", tk_obs_4, 64'd0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      start_block(P2V, T2V, K2V);
      while (!out_valid_4 && cyc < 700) tick();
      $display("post-reset ct=%h cycle=%0d", ct_4, cyc);
      check("post_lat", 64'(cyc), 64'd513);
      check("post_ct", ct_4, exp2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
